// File: rtl/huffman_min2_scan_pkg.sv
// huffman_min2_scan_pkg: shared widths, frame layout and FSM encoding for the min-2 scanner
package huffman_min2_scan_pkg;
    localparam int FREQ_W_DEF  = 27;
    localparam int ID_W_DEF    = 9;
    localparam int CNT_W_DEF   = 9;
    localparam int FRAME_W_DEF = FREQ_W_DEF + ID_W_DEF;
    localparam int FREQ_LSB    = 0;
    localparam int ID_LSB      = FREQ_W_DEF;
    typedef enum logic {SCAN = 1'b0, DONE = 1'b1} state_e;
endpackage

// File: rtl/huffman_min2_scan_if.sv
// huffman_min2_scan_if: node-frame input stream and min-2 result channel
interface huffman_min2_scan_if
    import huffman_min2_scan_pkg::*;
#(
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int ID_W   = ID_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();
    localparam int FRAME_W = FREQ_W + ID_W;
    logic               in_valid;
    logic               in_ready;
    logic [FRAME_W-1:0] in_frame;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [FRAME_W-1:0] out_min1;
    logic [FRAME_W-1:0] out_min2;
    logic               out_min2_vld;
    logic [CNT_W-1:0]   out_count;
    modport slave (
        input  in_valid, in_frame, in_last, out_ready,
        output in_ready, out_valid, out_min1, out_min2, out_min2_vld, out_count
    );
    modport master (
        output in_valid, in_frame, in_last, out_ready,
        input  in_ready, out_valid, out_min1, out_min2, out_min2_vld, out_count
    );
endinterface

// File: rtl/huffman_min2_scan_node_less.sv
// huff_node_less: combinational a<b on {id, freq} frames
// HUFF_ID_TIEBREAK_EN: equal freqs order by smaller id; otherwise equal freqs are never less
module huff_node_less
    import huffman_min2_scan_pkg::*;
#(
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int ID_W   = ID_W_DEF
) (
    input  logic [FREQ_W+ID_W-1:0] a_i,
    input  logic [FREQ_W+ID_W-1:0] b_i,
    output logic                   less_o
);
    logic [FREQ_W-1:0] fa, fb;
    always_comb begin
        fa = a_i[FREQ_LSB +: FREQ_W];
        fb = b_i[FREQ_LSB +: FREQ_W];
`ifdef HUFF_ID_TIEBREAK_EN
        less_o = (fa < fb) || (fa == fb && a_i[FREQ_W +: ID_W] < b_i[FREQ_W +: ID_W]);
`else
        less_o = fa < fb;
`endif
    end
endmodule

// File: rtl/huffman_min2_scan.sv
// huffman_min2_scan: tracks the two smallest node frames of a stream and presents them once per stream
// HUFF_ID_TIEBREAK_EN selects id tie-breaking on equal frequencies
module huffman_min2_scan
    import huffman_min2_scan_pkg::*;
#(
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int ID_W   = ID_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    huffman_min2_scan_if.slave bus
);
    localparam int FRAME_W = FREQ_W + ID_W;
    state_e             state_q;
    logic [FRAME_W-1:0] min1_q, min2_q;
    logic               v1_q, v2_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               less1, less2, accept;
    huff_node_less #(.FREQ_W(FREQ_W), .ID_W(ID_W)) u_less1 (
        .a_i(bus.in_frame), .b_i(min1_q), .less_o(less1)
    );
    huff_node_less #(.FREQ_W(FREQ_W), .ID_W(ID_W)) u_less2 (
        .a_i(bus.in_frame), .b_i(min2_q), .less_o(less2)
    );
    always_comb begin
        accept = bus.in_valid && state_q == SCAN;
        cnt_d  = &cnt_q ? cnt_q : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SCAN;
            min1_q  <= '0;
            min2_q  <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            // a new minimum demotes the old one, keeping min1 <= min2
            if (!v1_q || less1) begin
                min2_q <= min1_q;
                v2_q   <= v1_q;
                min1_q <= bus.in_frame;
                v1_q   <= 1'b1;
            end else if (!v2_q || less2) begin
                min2_q <= bus.in_frame;
                v2_q   <= 1'b1;
            end
            cnt_q <= cnt_d;
            if (bus.in_last) state_q <= DONE;
        end else if (state_q == DONE && bus.out_ready) begin
            state_q <= SCAN;
            min1_q  <= '0;
            min2_q  <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            cnt_q   <= '0;
        end
    end
    always_comb begin
        bus.in_ready     = state_q == SCAN;
        bus.out_valid    = state_q == DONE;
        bus.out_min1     = min1_q;
        bus.out_min2     = min2_q;
        bus.out_min2_vld = v2_q && state_q == DONE;
        bus.out_count    = cnt_q;
    end
endmodule

// File: tb/tb_huffman_min2_scan.sv
// tb_huffman_min2_scan: directed and randomized streams checked against a sort-based reference model
module tb_huffman_min2_scan;
    localparam int FREQ_W = 27;
    localparam int ID_W   = 9;
    localparam int CNT_W  = 9;
    localparam int FW     = FREQ_W + ID_W;
    typedef logic [FW-1:0] frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    huffman_min2_scan_if #(.FREQ_W(FREQ_W), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();
    huffman_min2_scan #(.FREQ_W(FREQ_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int passed = 0;
    int total = 0;
    logic ok;
    frame_t r1, r2;
    logic rv;
    logic [CNT_W-1:0] rc;

    function automatic frame_t mk(int id, int f);
        return {ID_W'(id), FREQ_W'(f)};
    endfunction

    function automatic bit mless(frame_t a, frame_t b);
        if (a[FREQ_W-1:0] != b[FREQ_W-1:0]) return a[FREQ_W-1:0] < b[FREQ_W-1:0];
`ifdef HUFF_ID_TIEBREAK_EN
        return a[FW-1:FREQ_W] < b[FW-1:FREQ_W];
`else
        return 1'b0;
`endif
    endfunction

    // stable selection: the earliest among equally ranked frames wins
    task automatic model(input frame_t q[$], output frame_t e1, output frame_t e2,
                         output logic ev, output logic [CNT_W-1:0] ec);
        int i1 = 0;
        int i2 = -1;
        for (int i = 1; i < q.size(); i++) if (mless(q[i], q[i1])) i1 = i;
        for (int i = 0; i < q.size(); i++)
            if (i != i1 && (i2 < 0 || mless(q[i], q[i2]))) i2 = i;
        e1 = q[i1];
        e2 = (i2 < 0) ? '0 : q[i2];
        ev = i2 >= 0;
        ec = (q.size() > 511) ? CNT_W'(511) : CNT_W'(q.size());
    endtask

    task automatic beat(input frame_t f, input bit last);
        bus.in_valid = 1'b1;
        bus.in_frame = f;
        bus.in_last  = last;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send(input frame_t q[$]);
        foreach (q[i]) beat(q[i], i == q.size() - 1);
    endtask

    task automatic collect();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        r1 = bus.out_min1;
        r2 = bus.out_min2;
        rv = bus.out_min2_vld;
        rc = bus.out_count;
        if (ok) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            $display("FAIL reset_hs ready/valid=%b want 10", {bus.in_ready, bus.out_valid});
        else passed++;
        total++;
        if ({bus.out_min1, bus.out_min2, bus.out_min2_vld, bus.out_count} !== '0)
            $display("FAIL reset_out min1=%h min2=%h vld=%b cnt=%0d want all zero",
                     bus.out_min1, bus.out_min2, bus.out_min2_vld, bus.out_count);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        send('{mk(0, 10), mk(1, 3), mk(2, 7), mk(3, 5)});
        total++;
        if (bus.out_valid !== 1'b1) $display("FAIL basic_latency out_valid=%b want 1", bus.out_valid);
        else passed++;
        collect();
        total++;
        if ({ok, r1, r2, rv, rc} !== {1'b1, mk(1, 3), mk(3, 5), 1'b1, CNT_W'(4)})
            $display("FAIL basic ok=%b min1=%h min2=%h vld=%b cnt=%0d want min1=%h min2=%h vld=1 cnt=4",
                     ok, r1, r2, rv, rc, mk(1, 3), mk(3, 5));
        else passed++;
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL basic_ready in_ready=%b want 1", bus.in_ready);
        else passed++;
    endtask

    task automatic test_single();
        send('{mk(4, 9)});
        collect();
        total++;
        if ({ok, r1, r2, rv, rc} !== {1'b1, mk(4, 9), frame_t'(0), 1'b0, CNT_W'(1)})
            $display("FAIL single ok=%b min1=%h min2=%h vld=%b cnt=%0d want min1=%h min2=0 vld=0 cnt=1",
                     ok, r1, r2, rv, rc, mk(4, 9));
        else passed++;
    endtask

    task automatic test_tie();
        frame_t e1, e2;
`ifdef HUFF_ID_TIEBREAK_EN
        e1 = mk(2, 5);
        e2 = mk(7, 5);
`else
        e1 = mk(7, 5);
        e2 = mk(2, 5);
`endif
        send('{mk(7, 5), mk(2, 5)});
        collect();
        total++;
        if ({ok, r1, r2, rv, rc} !== {1'b1, e1, e2, 1'b1, CNT_W'(2)})
            $display("FAIL tie ok=%b min1=%h min2=%h vld=%b cnt=%0d want min1=%h min2=%h vld=1 cnt=2",
                     ok, r1, r2, rv, rc, e1, e2);
        else passed++;
    endtask

    task automatic test_backpressure();
        send('{mk(2, 20), mk(6, 11)});
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_frame = mk(9, 1);
            @(posedge clk); #1;
            total++;
            if ({bus.in_ready, bus.out_valid, bus.out_min1, bus.out_min2, bus.out_min2_vld, bus.out_count}
                !== {1'b0, 1'b1, mk(6, 11), mk(2, 20), 1'b1, CNT_W'(2)})
                $display("FAIL hold[%0d] rdy=%b vld=%b min1=%h min2=%h v2=%b cnt=%0d want rdy=0 vld=1 min1=%h min2=%h v2=1 cnt=2",
                         i, bus.in_ready, bus.out_valid, bus.out_min1, bus.out_min2,
                         bus.out_min2_vld, bus.out_count, mk(6, 11), mk(2, 20));
            else passed++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.out_count} !== {1'b1, 1'b0, CNT_W'(0)})
            $display("FAIL release rdy=%b vld=%b cnt=%0d want rdy=1 vld=0 cnt=0",
                     bus.in_ready, bus.out_valid, bus.out_count);
        else passed++;
        send('{mk(3, 8)});
        collect();
        total++;
        if ({ok, r1, rv, rc} !== {1'b1, mk(3, 8), 1'b0, CNT_W'(1)})
            $display("FAIL after_release ok=%b min1=%h vld=%b cnt=%0d want min1=%h vld=0 cnt=1",
                     ok, r1, rv, rc, mk(3, 8));
        else passed++;
    endtask

    task automatic test_mid_reset();
        beat(mk(5, 1), 1'b0);
        beat(mk(6, 2), 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send('{mk(1, 4)});
        collect();
        total++;
        if ({ok, r1, r2, rv, rc} !== {1'b1, mk(1, 4), frame_t'(0), 1'b0, CNT_W'(1)})
            $display("FAIL mid_reset ok=%b min1=%h min2=%h vld=%b cnt=%0d want min1=%h min2=0 vld=0 cnt=1",
                     ok, r1, r2, rv, rc, mk(1, 4));
        else passed++;
    endtask

    task automatic test_saturate();
        frame_t q[$], e1, e2;
        logic ev;
        logic [CNT_W-1:0] ec;
        for (int i = 0; i < 600; i++) q.push_back(mk($urandom_range(0, 511), $urandom_range(1, 100000)));
        model(q, e1, e2, ev, ec);
        send(q);
        collect();
        total++;
        if ({ok, r1, r2, rv, rc} !== {1'b1, e1, e2, ev, ec})
            $display("FAIL saturate ok=%b min1=%h min2=%h vld=%b cnt=%0d want min1=%h min2=%h vld=%b cnt=%0d",
                     ok, r1, r2, rv, rc, e1, e2, ev, ec);
        else passed++;
    endtask

    task automatic test_random();
        for (int s = 0; s < 12; s++) begin
            frame_t q[$], e1, e2;
            logic ev;
            logic [CNT_W-1:0] ec;
            int n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) q.push_back(mk($urandom_range(0, 7), $urandom_range(0, 5)));
            model(q, e1, e2, ev, ec);
            send(q);
            collect();
            total++;
            if ({ok, r1, r2, rv, rc} !== {1'b1, e1, e2, ev, ec})
                $display("FAIL random[%0d] n=%0d ok=%b min1=%h min2=%h vld=%b cnt=%0d want min1=%h min2=%h vld=%b cnt=%0d",
                         s, n, ok, r1, r2, rv, rc, e1, e2, ev, ec);
            else passed++;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_frame  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_tie();
        test_backpressure();
        test_mid_reset();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
